peecc_uart_word_bridge: RTL and testbench

//  Parametrised UART-to-word bridge between the FTDI serial pins and the PEECC encoder core.
//  RX: assembles a framed serial byte stream into DIN_W-bit words with a valid/ready handshake.
//  TX: serialises DOUT_W-bit encoder results back out as framed bytes.

---
 rtl/peecc_uart_word_bridge_pkg.sv | 31 +++
 rtl/peecc_uart_word_bridge_phy.sv | 120 ++++++++++++
 rtl/peecc_uart_word_bridge.sv | 178 +++++++++++++++++
 tb/tb_peecc_uart_word_bridge.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/peecc_uart_word_bridge_pkg.sv
// Shared constants, state encodings and sizing helpers
// for the PEECC UART word bridge.
package peecc_uart_word_bridge_pkg;

    localparam logic [7:0] SYNC_RX_DEF = 8'hA5;
    localparam logic [7:0] SYNC_TX_DEF = 8'h5A;

    typedef enum logic [1:0] {
        R_SYNC,
        R_DATA,
        R_HOLD
    } rx_state_e;

    typedef enum logic [1:0] {
        T_IDLE,
        T_SYNC,
        T_DATA
    } tx_state_e;

    typedef enum logic [1:0] {
        P_IDLE,
        P_START,
        P_BITS,
        P_STOP
    } phy_rx_e;

    function automatic int bytes_for(input int width);
        return (width + 7) / 8;
    endfunction

endpackage

// File: rtl/peecc_uart_word_bridge_phy.sv
// 8N1 UART PHY: input synchroniser, mid-bit receiver,
// and a transmitter that chains bytes without idle bits.
module peecc_uart_phy
    import peecc_uart_word_bridge_pkg::*;
#(
    parameter int CLKS_PER_BIT = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_line,
    output logic       tx_line,
    output logic       rx_vld,
    output logic [7:0] rx_byte,
    output logic       rx_err,
    input  logic       tx_start,
    input  logic [7:0] tx_byte,
    output logic       tx_busy
);

    localparam int CW = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic          s1, s2;
    phy_rx_e       prx, prx_d;
    logic [CW-1:0] cnt;
    logic [2:0]    bitn;
    logic [7:0]    sh;
    logic          mid, full;

    logic          tact;
    logic [9:0]    tsh;
    logic [CW-1:0] tcnt;
    logic [3:0]    tbit;

    assign mid     = (cnt == HALF);
    assign full    = (cnt == LAST);
    assign rx_byte = sh;

    // two-flop synchroniser for the asynchronous RX pin
    always_ff @(posedge clk) begin
        if (rst) begin
            s1 <= 1'b1;
            s2 <= 1'b1;
        end else begin
            s1 <= rx_line;
            s2 <= s1;
        end
    end

    // receiver next state: start re-check at mid-bit, then 8 data and stop
    always_comb begin
        prx_d = prx;
        unique case (prx)
            P_IDLE:  if (!s2) prx_d = P_START;
            P_START: if (mid) prx_d = s2 ? P_IDLE : P_BITS;
            P_BITS:  if (full && bitn == 3'd7) prx_d = P_STOP;
            P_STOP:  if (full) prx_d = P_IDLE;
        endcase
    end

    // receiver state, bit timer and LSB-first shifter
    always_ff @(posedge clk) begin
        if (rst) begin
            prx    <= P_IDLE;
            cnt    <= '0;
            bitn   <= '0;
            sh     <= '0;
            rx_vld <= 1'b0;
            rx_err <= 1'b0;
        end else begin
            prx    <= prx_d;
            rx_vld <= 1'b0;
            rx_err <= 1'b0;
            if (prx == P_IDLE || prx_d != prx || full) cnt <= '0;
            else cnt <= cnt + 1'b1;
            if (prx == P_START && prx_d == P_BITS) bitn <= '0;
            if (prx == P_BITS && full) begin
                sh   <= {s2, sh[7:1]};
                bitn <= bitn + 1'b1;
            end
            if (prx == P_STOP && full) begin
                rx_vld <= s2;
                rx_err <= !s2;
            end
        end
    end

    // free for a new byte in the last cycle of the stop bit
    assign tx_busy = tact && !(tbit == 4'd9 && tcnt == LAST);

    // transmitter shifter; line is registered so it is glitch-free
    always_ff @(posedge clk) begin
        if (rst) begin
            tact    <= 1'b0;
            tsh     <= '1;
            tcnt    <= '0;
            tbit    <= '0;
            tx_line <= 1'b1;
        end else begin
            tx_line <= tact ? tsh[0] : 1'b1;
            if (tx_start && !tx_busy) begin
                tsh  <= {1'b1, tx_byte, 1'b0};
                tcnt <= '0;
                tbit <= '0;
                tact <= 1'b1;
            end else if (tact) begin
                if (tcnt == LAST) begin
                    tcnt <= '0;
                    tsh  <= {1'b1, tsh[9:1]};
                    if (tbit == 4'd9) tact <= 1'b0;
                    else tbit <= tbit + 1'b1;
                end else begin
                    tcnt <= tcnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/peecc_uart_word_bridge.sv
// UART-to-word bridge: framing FSMs, inter-byte timeout
// and saturating RX error accounting around the UART PHY.
module peecc_uart_word_bridge
    import peecc_uart_word_bridge_pkg::*;
#(
    parameter int         DIN_W     = 32,
    parameter int         DOUT_W    = 42,
    parameter int         CLK_HZ    = 4000000,
    parameter int         BAUD      = 115200,
    parameter int         TIMEOUT_B = 20,
    parameter logic [7:0] SYNC_RX   = SYNC_RX_DEF,
    parameter logic [7:0] SYNC_TX   = SYNC_TX_DEF
) (
    input  logic              M_CLK_OSC,
    input  logic              M_RESET,
    input  logic              uart_rx,
    output logic              uart_tx,
    output logic [DIN_W-1:0]  din_data,
    output logic              din_valid,
    input  logic              din_ready,
    input  logic [DOUT_W-1:0] dout_data,
    input  logic              dout_valid,
    output logic              dout_ready,
    output logic              frame_err,
    output logic [7:0]        err_count,
    output logic              busy
);

    localparam int CPB    = CLK_HZ / BAUD;
    localparam int RXB    = bytes_for(DIN_W);
    localparam int TXB    = bytes_for(DOUT_W);
    localparam int RXW    = RXB * 8;
    localparam int TXW    = TXB * 8;
    localparam int TO_CYC = TIMEOUT_B * CPB;
    localparam int RIW    = $clog2(RXB + 1);
    localparam int TIW    = $clog2(TXB + 1);
    localparam int TW     = $clog2(TO_CYC + 1);
    localparam logic [RIW-1:0] RX_LAST = RIW'(RXB - 1);
    localparam logic [TIW-1:0] TX_END  = TIW'(TXB);
    localparam logic [TW-1:0]  TO_LAST = TW'(TO_CYC - 1);

    logic       rx_vld, rx_err, tx_start, tx_busy;
    logic [7:0] rx_byte, tx_byte;

    rx_state_e      rs, rs_d;
    logic [RIW-1:0] ridx;
    logic [RXW-1:0] rword;
    logic [TW-1:0]  tmr;
    logic           rx_fail;

    tx_state_e      ts, ts_d;
    logic [TIW-1:0] tidx;
    logic [TXW-1:0] tword;
    logic           load, adv, rdy_d;

    peecc_uart_phy #(
        .CLKS_PER_BIT(CPB)
    ) u_phy (
        .clk     (M_CLK_OSC),
        .rst     (M_RESET),
        .rx_line (uart_rx),
        .tx_line (uart_tx),
        .rx_vld  (rx_vld),
        .rx_byte (rx_byte),
        .rx_err  (rx_err),
        .tx_start(tx_start),
        .tx_byte (tx_byte),
        .tx_busy (tx_busy)
    );

    assign din_data  = rword[DIN_W-1:0];
    assign din_valid = (rs == R_HOLD);
    assign busy      = (rs != R_SYNC) || (ts != T_IDLE);

    // RX framing: hunt sync, collect bytes, hold word until accepted
    always_comb begin
        rs_d    = rs;
        rx_fail = 1'b0;
        unique case (rs)
            R_SYNC: begin
                if (rx_err) rx_fail = 1'b1;
                else if (rx_vld && rx_byte == SYNC_RX) rs_d = R_DATA;
            end
            R_DATA: begin
                if (rx_err) begin
                    rx_fail = 1'b1;
                    rs_d    = R_SYNC;
                end else if (rx_vld) begin
                    if (ridx == RX_LAST) rs_d = R_HOLD;
                end else if (tmr == TO_LAST) begin
                    rx_fail = 1'b1;
                    rs_d    = R_SYNC;
                end
            end
            R_HOLD: begin
                if (rx_vld || rx_err) rx_fail = 1'b1;
                if (din_ready) rs_d = R_SYNC;
            end
            default: rs_d = R_SYNC;
        endcase
    end

    // RX word assembly, inter-byte timer and error counter
    always_ff @(posedge M_CLK_OSC) begin
        if (M_RESET) begin
            rs        <= R_SYNC;
            ridx      <= '0;
            rword     <= '0;
            tmr       <= '0;
            frame_err <= 1'b0;
            err_count <= '0;
        end else begin
            rs        <= rs_d;
            frame_err <= rx_fail;
            if (rx_fail && err_count != 8'hFF) err_count <= err_count + 8'd1;
            if (rs == R_SYNC) ridx <= '0;
            if (rs == R_DATA && rx_vld) begin
                rword <= RXW'({rx_byte, rword} >> 8);
                ridx  <= ridx + 1'b1;
            end
            if (rs == R_DATA && !rx_vld) tmr <= tmr + 1'b1;
            else tmr <= '0;
        end
    end

    // TX framing: capture result, send sync then bytes LSB first
    always_comb begin
        ts_d     = ts;
        tx_start = 1'b0;
        tx_byte  = tword[7:0];
        load     = 1'b0;
        adv      = 1'b0;
        unique case (ts)
            T_IDLE: begin
                if (dout_valid && dout_ready) begin
                    ts_d = T_SYNC;
                    load = 1'b1;
                end
            end
            T_SYNC: begin
                tx_start = 1'b1;
                tx_byte  = SYNC_TX;
                if (!tx_busy) ts_d = T_DATA;
            end
            T_DATA: begin
                if (tidx != TX_END) begin
                    tx_start = 1'b1;
                    adv      = !tx_busy;
                end else if (!tx_busy) begin
                    ts_d = T_IDLE;
                end
            end
            default: ts_d = T_IDLE;
        endcase
        rdy_d = (ts_d == T_IDLE);
    end

    // TX state, result shift register and registered ready
    always_ff @(posedge M_CLK_OSC) begin
        if (M_RESET) begin
            ts         <= T_IDLE;
            tidx       <= '0;
            tword      <= '0;
            dout_ready <= 1'b0;
        end else begin
            ts         <= ts_d;
            dout_ready <= rdy_d;
            if (load) begin
                tword <= TXW'(dout_data);
                tidx  <= '0;
            end else if (adv) begin
                tword <= tword >> 8;
                tidx  <= tidx + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_peecc_uart_word_bridge.sv
// Directed bench for the UART word bridge: RX word vectors,
// hold/overrun/timeout/stop-error cases, TX framing and reset.
module tb_peecc_uart_word_bridge;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        uart_rx = 1'b1;
    logic        uart_tx;
    logic [31:0] din_data;
    logic        din_valid;
    logic        din_ready = 1'b1;
    logic [41:0] dout_data = '0;
    logic        dout_valid = 1'b0;
    logic        dout_ready;
    logic        frame_err;
    logic [7:0]  err_count;
    logic        busy;

    always #5 clk = ~clk;

    peecc_uart_word_bridge #(
        .DIN_W    (32),
        .DOUT_W   (42),
        .CLK_HZ   (4000000),
        .BAUD     (400000),
        .TIMEOUT_B(20)
    ) dut (
        .M_CLK_OSC (clk),
        .M_RESET   (rst),
        .uart_rx   (uart_rx),
        .uart_tx   (uart_tx),
        .din_data  (din_data),
        .din_valid (din_valid),
        .din_ready (din_ready),
        .dout_data (dout_data),
        .dout_valid(dout_valid),
        .dout_ready(dout_ready),
        .frame_err (frame_err),
        .err_count (err_count),
        .busy      (busy)
    );

    int total = 0;
    int bad = 0;
    int n_rise = 0;
    int n_vcyc = 0;
    int n_ferr = 0;
    logic pv = 1'b0;
    logic [31:0] cap = '0;

    typedef struct {
        int          n;
        logic [63:0] bytes;
        logic [31:0] exp;
    } rxv_t;

    rxv_t rv [6];
    logic [7:0] txe [7];

    // observe valid rises, valid cycles and error pulses
    always @(negedge clk) begin
        if (din_valid && !pv) begin
            n_rise = n_rise + 1;
            cap = din_data;
        end
        if (din_valid) n_vcyc = n_vcyc + 1;
        if (frame_err) n_ferr = n_ferr + 1;
        pv = din_valid;
    end

    task automatic check(input string nm, input logic [63:0] got,
                         input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", nm, got, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        uart_rx = 1'b0;
        repeat (10) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            repeat (10) @(negedge clk);
        end
        uart_rx = stop_bit;
        repeat (10) @(negedge clk);
        uart_rx = 1'b1;
    endtask

    task automatic send_frame(input int n, input logic [63:0] bytes);
        for (int i = 0; i < n; i++) send_byte(bytes[8*i +: 8], 1'b1);
    endtask

    task automatic wait_rise(input int target, input int budget);
        for (int i = 0; i < budget && n_rise < target; i++) @(negedge clk);
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int r0, c0, f0, lat;
        logic [2:0] s;
        logic [9:0] f;
        logic rdy_hs, r;

        rv[0] = '{5, 64'h000000DEADBEEFA5, 32'hDEADBEEF};
        rv[1] = '{5, 64'h00000000000000A5, 32'h00000000};
        rv[2] = '{5, 64'h000000FFFFFFFFA5, 32'hFFFFFFFF};
        rv[3] = '{5, 64'h000000563412A5A5, 32'h563412A5};
        rv[4] = '{7, 64'h0004030201A51300, 32'h04030201};
        rv[5] = '{7, 64'h0001000080A55A5A, 32'h01000080};
        txe = '{8'h5A, 8'h01, 8'h55, 8'hAA, 8'h00, 8'hFF, 8'h03};

        repeat (4) @(negedge clk);
        check("rst_uart_tx", uart_tx, 1);
        check("rst_din_valid", din_valid, 0);
        check("rst_din_data", din_data, 0);
        check("rst_dout_ready", dout_ready, 0);
        check("rst_frame_err", frame_err, 0);
        check("rst_err_count", err_count, 0);
        check("rst_busy", busy, 0);
        rst = 1'b0;
        @(negedge clk);
        check("rdy_after_rst", dout_ready, 1);

        din_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            r0 = n_rise;
            c0 = n_vcyc;
            send_frame(rv[i].n, rv[i].bytes);
            wait_rise(r0 + 1, 40);
            repeat (3) @(negedge clk);
            check($sformatf("rx%0d_rise", i), n_rise - r0, 1);
            check($sformatf("rx%0d_data", i), cap, rv[i].exp);
            check($sformatf("rx%0d_plen", i), n_vcyc - c0, 1);
            check($sformatf("rx%0d_errs", i), err_count, 0);
        end

        din_ready = 1'b0;
        r0 = n_rise;
        send_frame(7, 64'h0004030201A51300);
        wait_rise(r0 + 1, 40);
        repeat (50) @(negedge clk);
        check("hold_valid", din_valid, 1);
        check("hold_data", din_data, 32'h04030201);
        din_ready = 1'b1;
        @(negedge clk);
        check("hold_release", din_valid, 0);

        f0 = n_ferr;
        lat = -1;
        send_frame(3, 64'h00000000002211A5);
        for (int i = 1; i <= 250; i++) begin
            @(negedge clk);
            if (n_ferr != f0 && lat < 0) lat = i;
        end
        check("to_pulses", n_ferr - f0, 1);
        check("to_latency", (lat >= 185 && lat <= 210), 1);
        check("to_err_count", err_count, 1);
        r0 = n_rise;
        send_frame(5, 64'h00000004030201A5);
        wait_rise(r0 + 1, 40);
        repeat (3) @(negedge clk);
        check("to_next_data", cap, 32'h04030201);

        din_ready = 1'b0;
        r0 = n_rise;
        send_frame(5, 64'h00000040302010A5);
        wait_rise(r0 + 1, 40);
        send_byte(8'hA5, 1'b1);
        repeat (20) @(negedge clk);
        check("ovr_err_count", err_count, 2);
        check("ovr_data", din_data, 32'h40302010);
        check("ovr_valid", din_valid, 1);
        din_ready = 1'b1;
        @(negedge clk);
        check("ovr_release", din_valid, 0);

        f0 = n_ferr;
        send_byte(8'hA5, 1'b1);
        send_byte(8'h11, 1'b0);
        repeat (300) @(negedge clk);
        check("stop_pulses", n_ferr - f0, 1);
        check("stop_err_count", err_count, 3);
        r0 = n_rise;
        send_frame(5, 64'h0000000D0C0B0AA5);
        wait_rise(r0 + 1, 40);
        repeat (3) @(negedge clk);
        check("stop_next_data", cap, 32'h0D0C0B0A);

        for (int i = 0; i < 50 && !dout_ready; i++) @(negedge clk);
        check("tx_rdy_idle", dout_ready, 1);
        dout_data = 42'h3_FF00_AA55_01;
        dout_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        dout_valid = 1'b0;
        s[2] = uart_tx;
        rdy_hs = dout_ready;
        @(negedge clk);
        s[1] = uart_tx;
        @(negedge clk);
        s[0] = uart_tx;
        check("tx_start_edge", s, 3'b110);
        check("tx_rdy_drop", rdy_hs, 0);
        repeat (4) @(negedge clk);
        for (int j = 0; j < 7; j++) begin
            r = 1'b1;
            for (int k = 0; k < 10; k++) begin
                f[k] = uart_tx;
                if (k == 0) r = dout_ready;
                repeat (10) @(negedge clk);
            end
            check($sformatf("tx_byte%0d", j), f, {1'b1, txe[j], 1'b0});
            check($sformatf("tx_rdy%0d", j), r, 0);
        end
        for (int i = 0; i < 30 && !dout_ready; i++) @(negedge clk);
        check("tx_rdy_back", dout_ready, 1);
        check("tx_busy_done", busy, 0);

        dout_data = 42'h1;
        dout_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        dout_valid = 1'b0;
        repeat (6) @(negedge clk);
        check("mid_tx_line", uart_tx, 0);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_line", uart_tx, 1);
        check("mid_rst_errs", err_count, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_rdy", dout_ready, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("mid_rst_rdy_up", dout_ready, 1);
        check("mid_rst_idle", uart_tx, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
